z80_int_ctrl: RTL and testbench

Vectored, prioritised interrupt controller sitting between up to eight peripheral request lines and the Z80 core's `nINT` input. It latches rising edges on the request lines, arbitrates by fixed priority against a mask and an in-service set, drives `nINT`, and answers the interrupt-acknowledge cycle (`nM1` and `nIORQ` both low) with an IM2 vector on the data bus. Software configures and services it through three I/O ports. It replaces the fixed vector responder on the top-level bus.

---
 rtl/z80_int_ctrl.sv | 164 ++++++++++++++++
 tb/tb_z80_int_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/z80_int_ctrl.sv
// rtl/z80_int_ctrl.sv - Vectored fixed-priority IM2 interrupt controller for the Z80 bus
module z80_int_ctrl #(
    parameter logic [7:0] BASE_PORT = 8'h40,
    parameter logic [7:0] VEC_BASE  = 8'hE0
) (
    input  logic       CLK,
    input  logic       fpga_reset,
    input  logic [7:0] irq_in,
    input  logic [7:0] A,
    input  logic [7:0] D_in,
    output logic [7:0] D_out,
    output logic       D_oe,
    input  logic       nM1,
    input  logic       nIORQ,
    input  logic       nRD,
    input  logic       nWR,
    output logic       nINT
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_n;

    logic [7:0] mask;
    logic [7:0] pend;
    logic [7:0] isr;
    logic [7:0] irq_q;
    logic [2:0] ack_idx;
    logic       wr_dec_q;

    logic [7:0] pend_n;
    logic [7:0] isr_n;
    logic [2:0] ack_idx_n;
    logic [7:0] d_out_n;
    logic       d_oe_n;
    logic       nint_n;

    logic [7:0] rise;
    logic [7:0] elig;
    logic [2:0] win;
    logic [3:0] cur;
    logic       req;
    logic       inta;
    logic       take;
    logic       wr_dec;
    logic       rd_dec;
    logic       wr_stb;
    logic       wr_mask;
    logic       wr_pend;
    logic       wr_eoi;

    assign rise    = irq_in & ~irq_q;
    assign elig    = pend & ~mask;
    assign inta    = !nM1 && !nIORQ;
    assign wr_dec  = !nIORQ && !nWR && nM1;
    assign rd_dec  = !nIORQ && !nRD && nM1;
    // A held strobe must act only once, so only its first sampled cycle counts.
    assign wr_stb  = wr_dec && !wr_dec_q;
    assign wr_mask = wr_stb && (A == BASE_PORT);
    assign wr_pend = wr_stb && (A == BASE_PORT + 8'd1);
    assign wr_eoi  = wr_stb && (A == BASE_PORT + 8'd2);
    assign take    = (state == REQ) && req && inta;

    // Priority encode the winning eligible source and the highest source in service.
    always_comb begin
        win = 3'd0;
        cur = 4'd8;
        for (int i = 7; i >= 0; i--) begin
            if (elig[i]) win = 3'(i);
            if (isr[i])  cur = 4'(i);
        end
        req = (elig != 8'h00) && ({1'b0, win} < cur);
    end

    // Next values of the pending and in-service sets; new edges always win.
    always_comb begin
        pend_n = pend;
        if (wr_pend) pend_n = pend_n & ~D_in;
        if (take)    pend_n[win] = 1'b0;
        pend_n = pend_n | rise;

        isr_n = isr;
        if (wr_eoi) isr_n = isr & (isr - 8'd1);
        if (take)   isr_n[win] = 1'b1;

        ack_idx_n = take ? win : ack_idx;
    end

    // Configuration and bookkeeping registers.
    always_ff @(posedge CLK) begin
        if (fpga_reset) begin
            mask     <= 8'hFF;
            pend     <= 8'h00;
            isr      <= 8'h00;
            irq_q    <= 8'h00;
            ack_idx  <= 3'd0;
            wr_dec_q <= 1'b0;
        end else begin
            if (wr_mask) mask <= D_in;
            pend     <= pend_n;
            isr      <= isr_n;
            irq_q    <= irq_in;
            ack_idx  <= ack_idx_n;
            wr_dec_q <= wr_dec;
        end
    end

    // State register together with the registered bus and interrupt outputs.
    always_ff @(posedge CLK) begin
        if (fpga_reset) begin
            state <= IDLE;
            nINT  <= 1'b1;
            D_oe  <= 1'b0;
            D_out <= 8'h00;
        end else begin
            state <= state_n;
            nINT  <= nint_n;
            D_oe  <= d_oe_n;
            D_out <= d_out_n;
        end
    end

    // Next-state logic; a request vanishing in REQ drops back before any INTA.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (req) state_n = REQ;
            REQ: begin
                if (!req)      state_n = IDLE;
                else if (inta) state_n = ACK;
            end
            ACK:  if (nIORQ) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Output decode: the latched vector owns the bus for the whole acknowledge.
    always_comb begin
        nint_n  = (state_n != REQ);
        d_oe_n  = 1'b0;
        d_out_n = 8'h00;
        if (state_n == ACK) begin
            d_oe_n  = 1'b1;
            d_out_n = VEC_BASE | {4'b0000, ack_idx_n, 1'b0};
        end else if (rd_dec) begin
            if (A == BASE_PORT) begin
                d_oe_n  = 1'b1;
                d_out_n = mask;
            end else if (A == BASE_PORT + 8'd1) begin
                d_oe_n  = 1'b1;
                d_out_n = pend;
            end else if (A == BASE_PORT + 8'd2) begin
                d_oe_n  = 1'b1;
                d_out_n = isr;
            end
        end
    end

endmodule

// File: tb/tb_z80_int_ctrl.sv
// tb/tb_z80_int_ctrl.sv - Scoreboard bench for z80_int_ctrl
module tb_z80_int_ctrl;

    logic       CLK = 1'b0;
    logic       fpga_reset = 1'b1;
    logic [7:0] irq_in = 8'h00;
    logic [7:0] A = 8'h00;
    logic [7:0] D_in = 8'h00;
    logic [7:0] D_out;
    logic       D_oe;
    logic       nM1 = 1'b1;
    logic       nIORQ = 1'b1;
    logic       nRD = 1'b1;
    logic       nWR = 1'b1;
    logic       nINT;

    int tests = 0;
    int fails = 0;
    logic [7:0] sb_q[$];
    logic       oe_prev = 1'b0;

    z80_int_ctrl dut (
        .CLK        (CLK),
        .fpga_reset (fpga_reset),
        .irq_in     (irq_in),
        .A          (A),
        .D_in       (D_in),
        .D_out      (D_out),
        .D_oe       (D_oe),
        .nM1        (nM1),
        .nIORQ      (nIORQ),
        .nRD        (nRD),
        .nWR        (nWR),
        .nINT       (nINT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Monitor: every new bus drive pops the expected byte from the scoreboard.
    always @(negedge CLK) begin
        if (D_oe && !oe_prev) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_drive", D_out, 8'hXX);
            end else begin
                check("sb_bus_data", D_out, sb_q.pop_front());
            end
        end
        oe_prev = D_oe;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic io_write(input logic [7:0] addr, input logic [7:0] data);
        A = addr; D_in = data; nIORQ = 1'b0; nWR = 1'b0;
        tick();
        tick();
        nIORQ = 1'b1; nWR = 1'b1;
        tick();
    endtask

    task automatic io_read(input logic [7:0] addr, input logic [7:0] exp);
        sb_q.push_back(exp);
        A = addr; nIORQ = 1'b0; nRD = 1'b0;
        tick();
        tick();
        nIORQ = 1'b1; nRD = 1'b1;
        tick();
        check("read_oe_release", {7'd0, D_oe}, 8'h00);
    endtask

    task automatic inta(input logic [7:0] exp_vec, input logic [7:0] irq_during);
        sb_q.push_back(exp_vec);
        nM1 = 1'b0; nIORQ = 1'b0;
        tick();
        check("inta_nint_high", {7'd0, nINT}, 8'h01);
        irq_in = irq_during;
        tick();
        irq_in = 8'h00;
        nM1 = 1'b1; nIORQ = 1'b1;
        tick();
        check("inta_oe_release", {7'd0, D_oe}, 8'h00);
    endtask

    task automatic pulse(input logic [7:0] bits, input logic exp_nint);
        irq_in = bits;
        tick();
        check("pulse_nint_n1", {7'd0, nINT}, 8'h01);
        irq_in = 8'h00;
        tick();
        check("pulse_nint_n2", {7'd0, nINT}, {7'd0, exp_nint});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tick();
        tick();
        check("rst_nint", {7'd0, nINT}, 8'h01);
        check("rst_oe", {7'd0, D_oe}, 8'h00);
        check("rst_dout", D_out, 8'h00);
        fpga_reset = 1'b0;
        tick();
        io_read(8'h40, 8'hFF);
        io_read(8'h41, 8'h00);
        io_read(8'h42, 8'h00);

        // Basic single interrupt on source 3.
        io_write(8'h40, 8'h00);
        pulse(8'h08, 1'b0);
        inta(8'hE6, 8'h00);
        io_read(8'h41, 8'h00);
        io_read(8'h42, 8'h08);

        // Lower priority blocked while 3 in service; EOI releases it.
        pulse(8'h20, 1'b1);
        tick();
        check("blocked_nint", {7'd0, nINT}, 8'h01);
        io_write(8'h42, 8'h00);
        check("eoi_nint", {7'd0, nINT}, 8'h00);
        // Source 0 edge arrives during the acknowledge and is held.
        inta(8'hEA, 8'h01);
        check("ack_hold_nint", {7'd0, nINT}, 8'h01);
        tick();
        check("ack_reassert_nint", {7'd0, nINT}, 8'h00);
        inta(8'hE0, 8'h00);
        io_read(8'h42, 8'h21);
        io_write(8'h42, 8'h00);
        io_write(8'h42, 8'h00);
        io_read(8'h42, 8'h00);

        // Nested request: source 1 preempts source 3.
        pulse(8'h08, 1'b0);
        inta(8'hE6, 8'h00);
        pulse(8'h02, 1'b0);
        inta(8'hE2, 8'h00);
        io_read(8'h42, 8'h0A);
        io_write(8'h42, 8'h00);
        io_read(8'h42, 8'h08);
        io_write(8'h42, 8'h00);

        // Mask write while requesting withdraws nINT.
        pulse(8'h04, 1'b0);
        io_write(8'h40, 8'hFF);
        check("mask_withdraw_nint", {7'd0, nINT}, 8'h01);
        io_write(8'h41, 8'hFF);
        io_read(8'h41, 8'h00);

        // Masked source 0 alongside source 7.
        io_write(8'h40, 8'h01);
        pulse(8'h81, 1'b0);
        inta(8'hEE, 8'h00);
        io_read(8'h41, 8'h01);
        io_read(8'h42, 8'h80);
        io_write(8'h42, 8'h00);

        // Write-1-to-clear racing a new edge: the edge wins.
        io_write(8'h40, 8'hFF);
        io_write(8'h41, 8'hFF);
        A = 8'h41; D_in = 8'h80; nIORQ = 1'b0; nWR = 1'b0; irq_in = 8'h80;
        tick();
        irq_in = 8'h00;
        tick();
        nIORQ = 1'b1; nWR = 1'b1;
        tick();
        io_read(8'h41, 8'h80);

        // Reset in the middle of an acknowledge.
        io_write(8'h40, 8'h00);
        check("pre_reset_nint", {7'd0, nINT}, 8'h00);
        sb_q.push_back(8'hEE);
        nM1 = 1'b0; nIORQ = 1'b0;
        tick();
        check("ack_oe", {7'd0, D_oe}, 8'h01);
        fpga_reset = 1'b1;
        tick();
        check("reset_ack_oe", {7'd0, D_oe}, 8'h00);
        check("reset_ack_nint", {7'd0, nINT}, 8'h01);
        fpga_reset = 1'b0;
        nM1 = 1'b1; nIORQ = 1'b1;
        tick();
        io_read(8'h40, 8'hFF);
        io_read(8'h41, 8'h00);
        io_read(8'h42, 8'h00);

        tick();
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL sb_leftover: got %0d entries expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
